// File: rtl/lspcu_pipe_if.sv
//------------------------------------------------------------------------------
// lspcu_lsu_if / lspcu_mem_if : LSU-side and bus-side bundles of lspcu_pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lspcu_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [BW-1:0]         wr_req_ben;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  rd_resp_valid;
  logic                  rd_resp_ready;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  wr_resp_valid;
  logic                  wr_resp_ready;

  // master = LSU, slave = converter
  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_ben,
           wr_req_data, rd_resp_ready, wr_resp_ready,
    input  rd_req_ready, wr_req_ready, rd_resp_valid, rd_resp_data, wr_resp_valid
  );
  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_ben,
           wr_req_data, rd_resp_ready, wr_resp_ready,
    output rd_req_ready, wr_req_ready, rd_resp_valid, rd_resp_data, wr_resp_valid
  );
endinterface

interface lspcu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BW-1:0]         mem_ben;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_WIDTH-1:0] mem_dout;

  // master = converter, slave = memory / crossbar port
  modport master (
    output mem_req, mem_wr, mem_addr, mem_ben, mem_din,
    input  mem_addr_ok, mem_data_ok, mem_dout
  );
  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_ben, mem_din,
    output mem_addr_ok, mem_data_ok, mem_dout
  );
endinterface

`default_nettype wire

// File: rtl/lspcu_pipe.sv
//------------------------------------------------------------------------------
// lspcu_pipe : pipelined LSU-to-SRAM-bus converter, up to MAX_OUTS in flight,
//              in-order responses. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lspcu_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTS   = 4,
  parameter int ARB_MODE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  lspcu_lsu_if.slave  lsu,
  lspcu_mem_if.master mem,
  output logic        busy_o,
  output logic        err_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(MAX_OUTS);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

  logic [CW-1:0]         count_q, count_d;
  logic                  lock_q, lock_d;
  logic                  lock_wr_q, lock_wr_d;
  logic                  last_wr_q, last_wr_d;
  logic                  err_q, err_d;
  logic [PW:0]           tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW:0]           rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic                  tag_mem_q  [MAX_OUTS];
  logic                  rsp_type_q [MAX_OUTS];
  logic [DATA_WIDTH-1:0] rsp_data_q [MAX_OUTS];

  logic grant_wr;
  logic mem_req;
  logic xfer;
  logic tag_empty;
  logic rsp_empty;
  logic ret_ok;
  logic head_wr;
  logic rsp_pop;

  assign mem_req   = (lsu.rd_req_valid | lsu.wr_req_valid) & (count_q < MAX_CNT);
  assign xfer      = mem_req & mem.mem_addr_ok;
  assign tag_empty = (tag_wp_q == tag_rp_q);
  assign rsp_empty = (rsp_wp_q == rsp_rp_q);
  assign ret_ok    = mem.mem_data_ok & ~tag_empty;
  assign head_wr   = rsp_type_q[rsp_rp_q[PW-1:0]];
  assign rsp_pop   = ~rsp_empty & (head_wr ? lsu.wr_resp_ready : lsu.rd_resp_ready);

  // A stalled request keeps its grant so the bus sees a stable payload.
  always_comb begin
    grant_wr = 1'b0;
    if (lock_q) begin
      grant_wr = lock_wr_q;
    end else if (lsu.rd_req_valid && lsu.wr_req_valid) begin
      if (ARB_MODE == 0) begin
        grant_wr = 1'b0;
      end else if (ARB_MODE == 1) begin
        grant_wr = 1'b1;
      end else begin
        grant_wr = ~last_wr_q;
      end
    end else begin
      grant_wr = lsu.wr_req_valid;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_wr_d = lock_wr_q;
    last_wr_d = last_wr_q;
    if (mem_req && !mem.mem_addr_ok) begin
      lock_d    = 1'b1;
      lock_wr_d = grant_wr;
    end else if (xfer) begin
      lock_d    = 1'b0;
      last_wr_d = grant_wr;
    end

    unique case ({xfer, rsp_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    tag_wp_d = xfer    ? tag_wp_q + PTR_ONE : tag_wp_q;
    tag_rp_d = ret_ok  ? tag_rp_q + PTR_ONE : tag_rp_q;
    rsp_wp_d = ret_ok  ? rsp_wp_q + PTR_ONE : rsp_wp_q;
    rsp_rp_d = rsp_pop ? rsp_rp_q + PTR_ONE : rsp_rp_q;

    // A return with nothing outstanding is dropped and flagged.
    err_d = err_q | (mem.mem_data_ok & tag_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_wr_q <= 1'b0;
      last_wr_q <= 1'b1;
      err_q     <= 1'b0;
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      rsp_wp_q  <= '0;
      rsp_rp_q  <= '0;
    end else begin
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_wr_q <= lock_wr_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      tag_wp_q  <= tag_wp_d;
      tag_rp_q  <= tag_rp_d;
      rsp_wp_q  <= rsp_wp_d;
      rsp_rp_q  <= rsp_rp_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (xfer) begin
      tag_mem_q[tag_wp_q[PW-1:0]] <= grant_wr;
    end
    if (ret_ok) begin
      rsp_type_q[rsp_wp_q[PW-1:0]] <= tag_mem_q[tag_rp_q[PW-1:0]];
      rsp_data_q[rsp_wp_q[PW-1:0]] <= mem.mem_dout;
    end
  end

  assign mem.mem_req  = mem_req;
  assign mem.mem_wr   = mem_req & grant_wr;
  assign mem.mem_addr = !mem_req ? '0 : (grant_wr ? lsu.wr_req_addr : lsu.rd_req_addr);
  assign mem.mem_ben  = !mem_req ? '0 : (grant_wr ? lsu.wr_req_ben : {BW{1'b1}});
  assign mem.mem_din  = (mem_req & grant_wr) ? lsu.wr_req_data : '0;

  assign lsu.rd_req_ready  = xfer & ~grant_wr;
  assign lsu.wr_req_ready  = xfer & grant_wr;
  assign lsu.rd_resp_valid = ~rsp_empty & ~head_wr;
  assign lsu.wr_resp_valid = ~rsp_empty & head_wr;
  assign lsu.rd_resp_data  = rsp_data_q[rsp_rp_q[PW-1:0]];

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lspcu_pipe.sv
//------------------------------------------------------------------------------
// tb_lspcu_pipe : directed stimulus with scoreboard for lspcu_pipe. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lspcu_pipe;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  lspcu_lsu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu ();
  lspcu_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  lspcu_pipe #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_OUTS  (4),
    .ARB_MODE  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .lsu   (lsu),
    .mem   (mem),
    .busy_o(busy),
    .err_o (err)
  );

  logic [32:0] exp_q[$];   // {is_write, read data}
  logic [31:0] bus_q[$];   // data the bus model returns, in issue order
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_resp(input logic is_wr, input logic [31:0] d);
    exp_q.push_back({is_wr, d});
    bus_q.push_back(d);
  endtask

  task automatic bus_return(input int n);
    for (int i = 0; i < n; i++) begin
      mem.mem_data_ok = 1'b1;
      mem.mem_dout    = (bus_q.size() != 0) ? bus_q.pop_front() : 32'h0;
      tick();
    end
    mem.mem_data_ok = 1'b0;
    mem.mem_dout    = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every response handshake is compared against the scoreboard head.
  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (!rst) begin
      if (lsu.rd_resp_valid && lsu.rd_resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_resp_unexpected: actual=%0h expected=none", lsu.rd_resp_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_resp_order_is_wr", 64'(e[32]), 64'(0));
          check("rd_resp_data", 64'(lsu.rd_resp_data), 64'(e[31:0]));
        end
      end
      if (lsu.wr_resp_valid && lsu.wr_resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_resp_unexpected: actual=1 expected=none");
        end else begin
          e = exp_q.pop_front();
          check("wr_resp_order_is_wr", 64'(e[32]), 64'(1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    lsu.rd_req_valid = 0; lsu.rd_req_addr = '0;
    lsu.wr_req_valid = 0; lsu.wr_req_addr = '0; lsu.wr_req_ben = '0; lsu.wr_req_data = '0;
    lsu.rd_resp_ready = 0; lsu.wr_resp_ready = 0;
    mem.mem_addr_ok = 0; mem.mem_data_ok = 0; mem.mem_dout = '0;
    repeat (3) tick();
    neg();
    check("rst_mem_req", 64'(mem.mem_req), 64'(0));
    check("rst_rd_resp_valid", 64'(lsu.rd_resp_valid), 64'(0));
    check("rst_wr_resp_valid", 64'(lsu.wr_resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rd_req_ready", 64'(lsu.rd_req_ready), 64'(0));
    rst = 1'b0;
    tick();

    // 1: single read, data three cycles after acceptance
    lsu.rd_req_valid = 1; lsu.rd_req_addr = 32'h100;
    mem.mem_addr_ok = 1; lsu.rd_resp_ready = 1; lsu.wr_resp_ready = 1;
    neg();
    check("t1_mem_req", 64'(mem.mem_req), 64'(1));
    check("t1_mem_wr", 64'(mem.mem_wr), 64'(0));
    check("t1_mem_addr", 64'(mem.mem_addr), 64'h100);
    check("t1_mem_ben", 64'(mem.mem_ben), 64'hF);
    check("t1_mem_din", 64'(mem.mem_din), 64'(0));
    check("t1_rd_ready", 64'(lsu.rd_req_ready), 64'(1));
    check("t1_wr_ready", 64'(lsu.wr_req_ready), 64'(0));
    expect_resp(1'b0, 32'hDEADBEEF);
    tick();
    lsu.rd_req_valid = 0; mem.mem_addr_ok = 0;
    neg();
    check("t1_busy", 64'(busy), 64'(1));
    tick();
    tick();
    mem.mem_data_ok = 1; mem.mem_dout = bus_q.pop_front();
    neg();
    check("t1_no_bypass", 64'(lsu.rd_resp_valid), 64'(0));
    tick();
    mem.mem_data_ok = 0; mem.mem_dout = '0;
    neg();
    check("t1_resp_valid", 64'(lsu.rd_resp_valid), 64'(1));
    check("t1_resp_data", 64'(lsu.rd_resp_data), 64'hDEADBEEF);
    tick();
    wait_idle("t1");

    // 2: five back-to-back reads, only four credits
    lsu.rd_req_valid = 1; mem.mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      lsu.rd_req_addr = 32'h200 + 32'(4 * i);
      neg();
      check("t2_accept", 64'(lsu.rd_req_ready), 64'(1));
      expect_resp(1'b0, 32'hA000_0000 + 32'(i));
      tick();
    end
    lsu.rd_req_addr = 32'h210;
    for (int i = 0; i < 3; i++) begin
      neg();
      check("t2_stall", 64'(mem.mem_req), 64'(0));
      tick();
    end
    mem.mem_data_ok = 1; mem.mem_dout = bus_q.pop_front();
    neg();
    check("t2_stall_dok", 64'(mem.mem_req), 64'(0));
    tick();
    mem.mem_data_ok = 0; mem.mem_dout = '0;
    neg();
    check("t2_first_resp", 64'(lsu.rd_resp_valid), 64'(1));
    check("t2_still_stalled", 64'(mem.mem_req), 64'(0));
    tick();
    neg();
    check("t2_resume_req", 64'(mem.mem_req), 64'(1));
    check("t2_resume_ready", 64'(lsu.rd_req_ready), 64'(1));
    check("t2_resume_addr", 64'(mem.mem_addr), 64'h210);
    expect_resp(1'b0, 32'hA000_0004);
    tick();
    lsu.rd_req_valid = 0; mem.mem_addr_ok = 0;
    bus_return(4);
    wait_idle("t2");

    // 3: round-robin after reset starts with read
    rst = 1; tick(); rst = 0;
    lsu.rd_req_valid = 1; lsu.wr_req_valid = 1; mem.mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic is_wr;
      is_wr = (i % 2) == 1;
      lsu.rd_req_addr = 32'h600 + 32'(4 * i);
      lsu.wr_req_addr = 32'h500 + 32'(4 * i);
      lsu.wr_req_ben  = 4'hF;
      lsu.wr_req_data = 32'h5555_0000 + 32'(i);
      neg();
      check("t3_mem_wr", 64'(mem.mem_wr), 64'(is_wr));
      check("t3_rd_ready", 64'(lsu.rd_req_ready), 64'(!is_wr));
      check("t3_wr_ready", 64'(lsu.wr_req_ready), 64'(is_wr));
      check("t3_mem_addr", 64'(mem.mem_addr), is_wr ? 64'(32'h500 + 32'(4 * i)) : 64'(32'h600 + 32'(4 * i)));
      check("t3_mem_din", 64'(mem.mem_din), is_wr ? 64'(32'h5555_0000 + 32'(i)) : 64'(0));
      expect_resp(is_wr, is_wr ? 32'h0 : 32'hB000_0000 + 32'(i));
      tick();
    end
    lsu.rd_req_valid = 0; lsu.wr_req_valid = 0; mem.mem_addr_ok = 0;
    bus_return(4);
    wait_idle("t3");

    // 4: stalled write keeps the bus stable while a read arrives
    lsu.wr_req_valid = 1; lsu.wr_req_addr = 32'h300; lsu.wr_req_ben = 4'h3;
    lsu.wr_req_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        lsu.rd_req_valid = 1; lsu.rd_req_addr = 32'h400;
      end
      neg();
      check("t4_hold_wr", 64'(mem.mem_wr), 64'(1));
      check("t4_hold_addr", 64'(mem.mem_addr), 64'h300);
      check("t4_hold_ben", 64'(mem.mem_ben), 64'h3);
      check("t4_hold_din", 64'(mem.mem_din), 64'hCAFEF00D);
      check("t4_hold_rd_ready", 64'(lsu.rd_req_ready), 64'(0));
      tick();
    end
    mem.mem_addr_ok = 1;
    neg();
    check("t4_wr_accept", 64'(lsu.wr_req_ready), 64'(1));
    check("t4_wr_accept_rd", 64'(lsu.rd_req_ready), 64'(0));
    expect_resp(1'b1, 32'h0);
    tick();
    lsu.wr_req_valid = 0;
    neg();
    check("t4_rd_next_wr", 64'(mem.mem_wr), 64'(0));
    check("t4_rd_next_addr", 64'(mem.mem_addr), 64'h400);
    check("t4_rd_next_ready", 64'(lsu.rd_req_ready), 64'(1));
    expect_resp(1'b0, 32'hC000_0001);
    tick();
    lsu.rd_req_valid = 0; mem.mem_addr_ok = 0;
    bus_return(2);
    wait_idle("t4");

    // 5: LSU back-pressure with four returned reads
    lsu.rd_resp_ready = 0; lsu.rd_req_valid = 1; mem.mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      lsu.rd_req_addr = 32'h800 + 32'(4 * i);
      expect_resp(1'b0, 32'hD000_0000 + 32'(i));
      tick();
    end
    lsu.rd_req_valid = 0; mem.mem_addr_ok = 0;
    bus_return(4);
    for (int c = 0; c < 10; c++) begin
      neg();
      check("t5_hold_valid", 64'(lsu.rd_resp_valid), 64'(1));
      check("t5_hold_data", 64'(lsu.rd_resp_data), 64'hD000_0000);
      check("t5_hold_busy", 64'(busy), 64'(1));
      tick();
    end
    lsu.rd_resp_ready = 1;
    wait_idle("t5");

    // 6: spurious return, then reset with two outstanding
    neg();
    check("t6_err_before", 64'(err), 64'(0));
    mem.mem_data_ok = 1; mem.mem_dout = 32'h55;
    tick();
    mem.mem_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      neg();
      check("t6_err_sticky", 64'(err), 64'(1));
      check("t6_no_rd_resp", 64'(lsu.rd_resp_valid), 64'(0));
      check("t6_no_wr_resp", 64'(lsu.wr_resp_valid), 64'(0));
      check("t6_idle_busy", 64'(busy), 64'(0));
      tick();
    end
    lsu.rd_resp_ready = 0; lsu.rd_req_valid = 1; mem.mem_addr_ok = 1;
    lsu.rd_req_addr = 32'h700; tick();
    lsu.rd_req_addr = 32'h704; tick();
    lsu.rd_req_valid = 0; mem.mem_addr_ok = 0;
    mem.mem_data_ok = 1; mem.mem_dout = 32'h77;
    tick();
    mem.mem_data_ok = 0;
    neg();
    check("t6_pre_busy", 64'(busy), 64'(1));
    check("t6_pre_resp", 64'(lsu.rd_resp_valid), 64'(1));
    rst = 1; tick(); rst = 0;
    neg();
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_resp", 64'(lsu.rd_resp_valid), 64'(0));
    check("t6_rst_err", 64'(err), 64'(0));
    mem.mem_data_ok = 1; mem.mem_dout = 32'h99;
    tick();
    mem.mem_data_ok = 0;
    neg();
    check("t6_stale_err", 64'(err), 64'(1));
    check("t6_stale_resp", 64'(lsu.rd_resp_valid), 64'(0));
    check("final_pending", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
